// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - two-requester round-robin arbiter in front of a single SPI master
module spi_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       wr0,
    input  logic       wr1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    input  logic [9:0] freq0,
    input  logic [9:0] freq1,
    output logic       ack0,
    output logic       ack1,
    output logic       err,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       m_start_w,
    output logic       m_start_r,
    output logic [7:0] m_addr,
    output logic [7:0] m_wdata,
    output logic [9:0] m_freq,
    input  logic [7:0] m_rdata,
    input  logic       m_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        issue_cnt;
    logic [15:0] wdog;
    logic        wdog_hit;
    logic        grant_id;
    logic        last_id;
    logic        m_wr;
    logic        err_q;
    logic        pick;

    // The counter value after this cycle's increment has reached the limit.
    assign wdog_hit = ({1'b0, wdog} + 17'd1) >= {1'b0, TIMEOUT};

    // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_id;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state strobes; a timeout in WAIT_CLR wins over a falling done.
    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        m_start_w = 1'b0;
        m_start_r = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req0 || req1) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                m_start_w = m_wr;
                m_start_r = ~m_wr;
                if (issue_cnt) begin
                    state_nx = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (wdog_hit) begin
                    state_nx = RESP;
                end else if (!m_done) begin
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (m_done || wdog_hit) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                ack0     = ~grant_id;
                ack1     = grant_id;
                err      = err_q;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Grant latching, ISSUE length, watchdog, read capture and fairness bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt <= 1'b0;
            wdog      <= 16'd0;
            grant_id  <= 1'b0;
            last_id   <= 1'b1;
            m_wr      <= 1'b0;
            err_q     <= 1'b0;
            rdata     <= 8'd0;
            m_addr    <= 8'd0;
            m_wdata   <= 8'd0;
            m_freq    <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    issue_cnt <= 1'b0;
                    if (req0 || req1) begin
                        grant_id <= pick;
                        m_wr     <= pick ? wr1 : wr0;
                        m_addr   <= pick ? addr1 : addr0;
                        m_wdata  <= pick ? wdata1 : wdata0;
                        m_freq   <= pick ? freq1 : freq0;
                        err_q    <= 1'b0;
                    end
                end
                ISSUE: begin
                    issue_cnt <= 1'b1;
                    wdog      <= 16'd0;
                end
                WAIT_CLR: begin
                    if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                    if (wdog_hit) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                    if (m_done) begin
                        if (!m_wr) begin
                            rdata <= m_rdata;
                        end
                    end else if (wdog_hit) begin
                        err_q <= 1'b1;
                    end
                end
                RESP: begin
                    last_id <= grant_id;
                end
                default: begin
                    issue_cnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed self-checking bench for spi_arbiter
module tb_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] addr0 = 8'd0, addr1 = 8'd0, wdata0 = 8'd0, wdata1 = 8'd0;
    logic [9:0] freq0 = 10'd0, freq1 = 10'd0;
    logic       ack0, ack1, err, busy, m_start_w, m_start_r;
    logic [7:0] rdata, m_addr, m_wdata;
    logic [9:0] m_freq;
    logic [7:0] m_rdata = 8'd0;
    logic       m_done = 1'b0;

    int n_asserts = 0;
    int n_fail = 0;

    // master model knobs
    int         clr_hold = 0;
    int         lat = 2;
    bit         hang = 1'b0;
    logic [7:0] rd_val = 8'd0;
    bit         mbusy = 1'b0;
    int         mcnt = 0;

    // monitor counters
    int n_sw = 0, n_sr = 0, n_a0 = 0, n_a1 = 0;

    always #5 clk = ~clk;

    spi_arbiter #(.TIMEOUT(16'd50)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .freq0(freq0), .freq1(freq1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .busy(busy),
        .m_start_w(m_start_w), .m_start_r(m_start_r),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_freq(m_freq),
        .m_rdata(m_rdata), .m_done(m_done)
    );

    // SPI master model: done falls clr_hold cycles after the first strobe, rises lat cycles after it
    always @(posedge clk) begin
        if (!rst) begin
            mbusy <= 1'b0;
        end else if ((m_start_w || m_start_r) && !mbusy) begin
            mbusy <= 1'b1;
            mcnt  <= 1;
            if (clr_hold == 0) m_done <= 1'b0;
        end else if (mbusy) begin
            mcnt <= mcnt + 1;
            if (mcnt == clr_hold) m_done <= 1'b0;
            if (mcnt == lat && !hang) begin
                m_done  <= 1'b1;
                m_rdata <= rd_val;
                mbusy   <= 1'b0;
            end
        end
    end

    // strobe and ack cycle counters
    always @(negedge clk) begin
        if (m_start_w) n_sw++;
        if (m_start_r) n_sr++;
        if (ack0) n_a0++;
        if (ack1) n_a1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack0 || ack1) && n < 200);
        chk("ack_seen", 32'(ack0 | ack1), 1);
    endtask

    initial begin
        int n;
        int s_sw, s_sr, s_a0, s_a1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_err", err, 0);
        chk("rst_start_w", m_start_w, 0);
        chk("rst_start_r", m_start_r, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_freq", m_freq, 0);
        rst = 1'b1;
        @(negedge clk);

        // single write from requester 0, minimum turnaround
        s_sw = n_sw; s_sr = n_sr; s_a0 = n_a0; s_a1 = n_a1;
        lat = 2; clr_hold = 0; rd_val = 8'hEE;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h12; wdata0 = 8'hA5; freq0 = 10'd2;
        @(negedge clk);
        chk("wr_start_w", m_start_w, 1);
        chk("wr_start_r", m_start_r, 0);
        chk("wr_m_addr", m_addr, 8'h12);
        chk("wr_m_wdata", m_wdata, 8'hA5);
        chk("wr_m_freq", m_freq, 10'd2);
        wait_ack(n);
        chk("wr_latency", n, 4);
        chk("wr_ack0", ack0, 1);
        chk("wr_ack1", ack1, 0);
        chk("wr_err", err, 0);
        chk("wr_m_addr_resp", m_addr, 8'h12);
        req0 = 1'b0;
        @(negedge clk);
        chk("wr_busy_after", busy, 0);
        chk("wr_ack0_after", ack0, 0);
        chk("wr_rdata_untouched", rdata, 0);
        chk("wr_strobe_w_cycles", n_sw - s_sw, 2);
        chk("wr_strobe_r_cycles", n_sr - s_sr, 0);
        chk("wr_ack0_count", n_a0 - s_a0, 1);
        chk("wr_ack1_count", n_a1 - s_a1, 0);

        // read from requester 1
        s_sw = n_sw; s_sr = n_sr; s_a1 = n_a1;
        lat = 4; rd_val = 8'h5C;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h34; freq1 = 10'd7;
        wait_ack(n);
        chk("rd_latency", n, 7);
        chk("rd_ack1", ack1, 1);
        chk("rd_ack0", ack0, 0);
        chk("rd_err", err, 0);
        chk("rd_rdata", rdata, 8'h5C);
        chk("rd_m_addr", m_addr, 8'h34);
        chk("rd_m_freq", m_freq, 10'd7);
        req1 = 1'b0;
        @(negedge clk);
        chk("rd_rdata_hold", rdata, 8'h5C);
        chk("rd_strobe_r_cycles", n_sr - s_sr, 2);
        chk("rd_strobe_w_cycles", n_sw - s_sw, 0);
        chk("rd_ack1_count", n_a1 - s_a1, 1);

        // contention straight after reset: 0,1,0,1
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("rst2_rdata", rdata, 0);
        s_a0 = n_a0; s_a1 = n_a1;
        lat = 2;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'hA0; wdata0 = 8'h0A;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 8'hB1; wdata1 = 8'h1B;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            chk("ct_latency", n, (k == 0) ? 5 : 6);
            chk("ct_ack1", ack1, k & 1);
            chk("ct_one_ack", 32'(ack0) + 32'(ack1), 1);
            chk("ct_m_addr", m_addr, (k & 1) ? 8'hB1 : 8'hA0);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("ct_busy_after", busy, 0);
        chk("ct_ack0_count", n_a0 - s_a0, 2);
        chk("ct_ack1_count", n_a1 - s_a1, 2);

        // stale done: done still high from the last transaction, falls late
        clr_hold = 6; lat = 9; rd_val = 8'h77;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h40;
        wait_ack(n);
        chk("stale_latency", n, 12);
        chk("stale_ack0", ack0, 1);
        chk("stale_err", err, 0);
        chk("stale_rdata", rdata, 8'h77);
        req0 = 1'b0;
        @(negedge clk);

        // timeout: master never raises done
        clr_hold = 0; hang = 1'b1; rd_val = 8'h11;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h55;
        wait_ack(n);
        chk("to_latency", n, 53);
        chk("to_ack1", ack1, 1);
        chk("to_ack0", ack0, 0);
        chk("to_err", err, 1);
        chk("to_rdata_kept", rdata, 8'h77);
        req1 = 1'b0;
        @(negedge clk);
        chk("to_busy_after", busy, 0);
        chk("to_err_after", err, 0);

        // recover, then one write so requester 0 is last served
        rst = 1'b0; hang = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat = 2;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h3C; wdata0 = 8'hC3; freq0 = 10'h3FF;
        wait_ack(n);
        chk("rec_latency", n, 5);
        chk("rec_ack0", ack0, 1);
        chk("rec_err", err, 0);
        chk("rec_m_freq", m_freq, 10'h3FF);
        req0 = 1'b0;
        @(negedge clk);

        // reset during WAIT_DONE aborts without an ack
        s_a0 = n_a0; s_a1 = n_a1;
        lat = 20;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 8'h66; wdata0 = 8'h99; freq0 = 10'd5;
        repeat (6) @(negedge clk);
        chk("ab_busy_before", busy, 1);
        chk("ab_m_addr_before", m_addr, 8'h66);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("ab_busy", busy, 0);
        chk("ab_ack0", ack0, 0);
        chk("ab_err", err, 0);
        chk("ab_start_w", m_start_w, 0);
        chk("ab_m_addr", m_addr, 0);
        chk("ab_m_wdata", m_wdata, 0);
        chk("ab_m_freq", m_freq, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("ab_no_ack0", n_a0 - s_a0, 0);
        chk("ab_no_ack1", n_a1 - s_a1, 0);

        // tie after reset goes to requester 0 again
        lat = 2; rd_val = 8'h9A;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 8'h01;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 8'h02;
        wait_ack(n);
        chk("tie_latency", n, 5);
        chk("tie_ack0", ack0, 1);
        chk("tie_ack1", ack1, 0);
        chk("tie_rdata", rdata, 8'h9A);
        chk("tie_m_addr", m_addr, 8'h01);
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16'hFFFF, max cycles allowed in WAIT_CLR plus WAIT_DONE before the transaction is declared failed.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req0/req1  input  1  level request from requester 0/1; held until its ack.
REQ-005 wr0/wr1  input  1  1 = write, 0 = read; valid while reqN high.
REQ-006 addr0/addr1, wdata0/wdata1  input  8  register address and write data; valid while reqN high.
REQ-007 freq0/freq1  input  10  SCK divider for that requester's transactions.
REQ-008 ack0/ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-009 err  output  1  qualifies ack: 1 = transaction timed out.
REQ-010 rdata  output  8  read data; valid in the ack cycle of a read.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 m_start_w, m_start_r  output  1  start strobes to the SPI master.
REQ-013 m_addr, m_wdata  output  8; m_freq  output  10  transaction fields to the master.
REQ-014 m_rdata  input  8; m_done  input  1  master read data and level done flag.

Function
REQ-015 States: IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP; encoding free.
REQ-016 IDLE: if any reqN is high, grant one, latch its wr/addr/wdata/freq into m_* registers and a grant-id bit, go to ISSUE; otherwise stay in IDLE.
REQ-017 Arbitration is round-robin: when only one request is high, grant it; when both are high, grant the requester not served last; after reset, requester 0 wins the first tie.
REQ-018 The "last served" bit updates only on ack, including an err ack.
REQ-019 ISSUE lasts exactly 2 cycles with m_start_w (write) or m_start_r (read) high; the other strobe stays low; then go to WAIT_CLR.
REQ-020 WAIT_CLR: wait until m_done == 0, then go to WAIT_DONE.
REQ-021 WAIT_DONE: wait until m_done == 1, then capture m_rdata into rdata and go to RESP.
REQ-022 Watchdog counter: cleared on entry to WAIT_CLR; increments every cycle in WAIT_CLR and WAIT_DONE; saturates.
REQ-023 If the watchdog reaches TIMEOUT, go to RESP with err = 1; rdata keeps its previous value.
REQ-024 RESP lasts 1 cycle: ackN is high for the granted requester only, err is valid, then go to IDLE.
REQ-025 Requesters drop reqN on the clock edge that ends the ack cycle; a reqN still high in IDLE is a new request.
REQ-026 m_addr, m_wdata and m_freq stay stable from ISSUE through RESP; request inputs are ignored outside IDLE.
REQ-027 Minimum turnaround is IDLE→ISSUE(2)→WAIT_CLR→WAIT_DONE→RESP: ack comes at least 5 cycles after grant.
REQ-028 rdata holds its value until the next successful read completes.
REQ-029 After a timeout the master state is undefined; recovery requires rst.

Reset
REQ-030 While rst == 0 at a clock edge, all of the following hold:
- state = IDLE;
- ack0, ack1, err, busy, m_start_w, m_start_r = 0;
- rdata, m_addr, m_wdata = 0; m_freq = 0;
- watchdog = 0; last-served bit = 1, so requester 0 wins the first tie.
REQ-031 Reset asserted mid-transaction aborts it without an ack; requesters re-issue afterwards.

Verification
REQ-032 Single write: req0 with wr0=1, addr0=8'h12, wdata0=8'hA5, freq0=10'd2 → m_start_w high for 2 cycles, m_addr=8'h12, m_wdata=8'hA5, m_freq=2; ack0 pulses once with err=0 one cycle after m_done rises; ack1 never asserts.
REQ-033 Read: req1 with wr1=0, addr1=8'h34, model returns 8'h5C → m_start_r pulses for 2 cycles; ack1 pulses with rdata=8'h5C and err=0.
REQ-034 Contention: req0 and req1 asserted in the same cycle after reset, both re-asserted after each ack, for 4 transactions → grant order is 0,1,0,1; exactly one ack per transaction.
REQ-035 Stale done: m_done held high from the previous transaction, then ISSUE → the block stays in WAIT_CLR until m_done falls; no early ack.
REQ-036 Timeout: TIMEOUT=16'd50, model never raises m_done → ack pulses with err=1 after 50 cycles of waiting; busy drops the cycle after.
REQ-037 Reset mid-transaction: rst=0 during WAIT_DONE → all outputs at reset values the next cycle; no ack is issued.
